// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: mode encoding, PWM width, duty scaling.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package led_seq_pkg;

    localparam int PWM_BITS = 8;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        COUNT   = 2'd1,
        CHASE   = 2'd2,
        BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Upper byte of level * brightness gives the breathe duty.
    function automatic logic [PWM_BITS-1:0] scale_duty(input logic [7:0] level,
                                                       input logic [7:0] bri);
        logic [15:0] prod;
        prod = {8'd0, level} * {8'd0, bri};
        return prod[15:8];
    endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter with duty comparator.
// Latency: pwm_on is combinational from the counter and duty.
// Backpressure: none; counter runs every cycle.
module led_pwm
    import led_seq_pkg::*;
(
    input  logic                clkusr_100m,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_on
);

    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clkusr_100m or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign pwm_on = (pwm_cnt < duty);

endmodule

// File: rtl/led_seq.sv
// Board LED pattern sequencer: OFF / COUNT / CHASE / BREATHE, stepped by a prescaler, dimmed by PWM.
// Latency: led_o registered one cycle after pattern/PWM change; tick_o combinational in the wrap cycle.
// Backpressure: none; mode_valid_i is a strobe that is always accepted.
module led_seq
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS     = 6,
    parameter int TICK_DIV     = 10_000_000,
    parameter int BREATHE_STEP = 8
) (
    input  logic                clkusr_100m,
    input  logic                rst_n,
    input  logic [1:0]          mode_i,
    input  logic                mode_valid_i,
    input  logic [7:0]          brightness_i,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                tick_o
);

    localparam int          PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0]  STEP8   = 8'(BREATHE_STEP);

    logic [1:0]          rst_sync;
    logic                rst_core_n;
    logic [PRESC_W-1:0]  presc;
    logic                wrap;
    logic                tick;
    mode_e               mode_q;
    mode_e               mode_d;
    logic [NUM_LEDS-1:0] step_cnt;
    logic [NUM_LEDS-1:0] chase_q;
    logic [7:0]          level_q;
    dir_e                dir_q;
    logic [8:0]          level_up;
    logic [NUM_LEDS-1:0] pattern;
    logic [PWM_BITS-1:0] duty;
    logic                pwm_on;

    // Assertion is immediate through the flops' async clear; release takes two edges.
    always_ff @(posedge clkusr_100m or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync[1];

    assign wrap   = (presc == PRESC_W'(TICK_DIV - 1));
    assign tick   = wrap & ~mode_valid_i & rst_core_n;
    assign tick_o = tick;

    always_ff @(posedge clkusr_100m or negedge rst_core_n) begin
        if (!rst_core_n) begin
            presc <= '0;
        end else if (mode_valid_i || wrap) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clkusr_100m or negedge rst_core_n) begin
        if (!rst_core_n) begin
            mode_q <= OFF;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_valid_i) begin
            mode_d = mode_e'(mode_i);
        end
    end

    assign level_up = {1'b0, level_q} + {1'b0, STEP8};

    // Pattern state restarts on every mode load and only advances in its own mode.
    always_ff @(posedge clkusr_100m or negedge rst_core_n) begin
        if (!rst_core_n) begin
            step_cnt <= '0;
            chase_q  <= NUM_LEDS'(1);
            level_q  <= 8'd0;
            dir_q    <= DIR_UP;
        end else if (mode_valid_i) begin
            step_cnt <= '0;
            chase_q  <= NUM_LEDS'(1);
            level_q  <= 8'd0;
            dir_q    <= DIR_UP;
        end else if (tick) begin
            case (mode_q)
                COUNT: step_cnt <= step_cnt + 1'b1;
                CHASE: chase_q  <= {chase_q[NUM_LEDS-2:0], chase_q[NUM_LEDS-1]};
                BREATHE: begin
                    if (dir_q == DIR_UP) begin
                        if (level_up >= 9'd255) begin
                            level_q <= 8'd255;
                            dir_q   <= DIR_DOWN;
                        end else begin
                            level_q <= level_up[7:0];
                        end
                    end else begin
                        if (level_q <= STEP8) begin
                            level_q <= 8'd0;
                            dir_q   <= DIR_UP;
                        end else begin
                            level_q <= level_q - STEP8;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pattern = '0;
        duty    = '0;
        case (mode_q)
            COUNT: begin
                pattern = step_cnt;
                duty    = brightness_i;
            end
            CHASE: begin
                pattern = chase_q;
                duty    = brightness_i;
            end
            BREATHE: begin
                pattern = '1;
                duty    = scale_duty(level_q, brightness_i);
            end
            default: ;
        endcase
    end

    led_pwm u_pwm (
        .clkusr_100m (clkusr_100m),
        .rst_n       (rst_core_n),
        .duty        (duty),
        .pwm_on      (pwm_on)
    );

    always_ff @(posedge clkusr_100m or negedge rst_core_n) begin
        if (!rst_core_n) begin
            led_o <= '0;
        end else begin
            led_o <= pattern & {NUM_LEDS{pwm_on}};
        end
    end

endmodule

// File: tb/tb_led_seq.sv
// Randomised bench for led_seq with a step-index reference model (TICK_DIV=4, NUM_LEDS=6, BREATHE_STEP=64).
module tb_led_seq;

    localparam int N    = 6;
    localparam int TD   = 4;
    localparam int BS   = 64;
    localparam int MAXC = 8192;

    logic         clkusr_100m = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   mode_i = 2'd0;
    logic         mode_valid_i = 1'b0;
    logic [7:0]   brightness_i = 8'd0;
    logic [N-1:0] led_o;
    logic         tick_o;

    led_seq #(.NUM_LEDS(N), .TICK_DIV(TD), .BREATHE_STEP(BS)) dut (
        .clkusr_100m  (clkusr_100m),
        .rst_n        (rst_n),
        .mode_i       (mode_i),
        .mode_valid_i (mode_valid_i),
        .brightness_i (brightness_i),
        .led_o        (led_o),
        .tick_o       (tick_o)
    );

    always #5 clkusr_100m = ~clkusr_100m;

    int checks = 0;
    int passes = 0;
    int c;
    int cur_L;
    int cur_mode;
    bit mv_h[MAXC];
    int md_h[MAXC];
    int br_h[MAXC];
    int L_h[MAXC];
    int mode_h[MAXC];

    // Model: cycle 0 is the first cycle with the core out of reset; L_h holds the
    // last load cycle before each cycle, so the step index is (x - L - 1) / TD.
    function automatic int lvl(int k);
        int  l  = 0;
        bit  up = 1'b1;
        for (int i = 0; i < k; i++) begin
            if (up) begin
                l = (l + BS > 255) ? 255 : l + BS;
                if (l == 255) up = 1'b0;
            end else begin
                l = (l - BS < 0) ? 0 : l - BS;
                if (l == 0) up = 1'b1;
            end
        end
        return l;
    endfunction

    function automatic int kstep(int x);
        return (x - L_h[x] - 1) / TD;
    endfunction

    function automatic int pat(int x);
        case (mode_h[x])
            1: return kstep(x) % (1 << N);
            2: return 1 << (kstep(x) % N);
            3: return (1 << N) - 1;
            default: return 0;
        endcase
    endfunction

    function automatic int duty_of(int x);
        case (mode_h[x])
            1, 2: return br_h[x];
            3: return (lvl(kstep(x)) * br_h[x]) / 256;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_led(int x);
        if (x == 0) return 0;
        return (((x - 1) % 256) < duty_of(x - 1)) ? pat(x - 1) : 0;
    endfunction

    function automatic bit exp_tick(int x);
        int base;
        base = (L_h[x] < 0) ? 0 : L_h[x] + 1;
        return !mv_h[x] && (((x - base) % TD) == TD - 1);
    endfunction

    task automatic model_reset();
        c         = 0;
        cur_L     = -1;
        cur_mode  = 0;
        L_h[0]    = -1;
        mode_h[0] = 0;
    endtask

    task automatic drive(input bit v, input int m, input int b);
        mode_valid_i = v;
        mode_i       = 2'(m);
        brightness_i = 8'(b);
        mv_h[c] = v;
        md_h[c] = m;
        br_h[c] = b;
        #1;
    endtask

    task automatic advance();
        @(posedge clkusr_100m);
        if (mv_h[c]) begin
            cur_L    = c;
            cur_mode = md_h[c];
        end
        c++;
        L_h[c]    = cur_L;
        mode_h[c] = cur_mode;
        @(negedge clkusr_100m);
    endtask

    task automatic do_reset();
        mode_valid_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clkusr_100m);
        rst_n = 1'b1;
        @(posedge clkusr_100m);
        @(posedge clkusr_100m);
        @(negedge clkusr_100m);
        model_reset();
    endtask

    task automatic test_reset();
        mode_valid_i = 1'b0;
        brightness_i = 8'd255;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkusr_100m);
            #1;
            checks++;
            if (led_o !== '0) $display("FAIL reset_led got=%b exp=000000", led_o);
            else passes++;
            checks++;
            if (tick_o !== 1'b0) $display("FAIL reset_tick got=%b exp=0", tick_o);
            else passes++;
        end
        rst_n = 1'b1;
        @(posedge clkusr_100m);
        @(posedge clkusr_100m);
        @(negedge clkusr_100m);
        model_reset();
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, $urandom_range(3), $urandom_range(255));
            checks++;
            if (led_o !== '0) $display("FAIL idle_led c=%0d got=%b exp=000000", c, led_o);
            else passes++;
            checks++;
            if (tick_o !== exp_tick(c)) $display("FAIL idle_tick c=%0d got=%b exp=%b", c, tick_o, exp_tick(c));
            else passes++;
            advance();
        end
    endtask

    task automatic test_count();
        for (int i = 0; i < 300; i++) begin
            drive(i == 0, 1, 255);
            checks++;
            if (led_o !== N'(exp_led(c))) $display("FAIL count_led c=%0d got=%b exp=%b", c, led_o, N'(exp_led(c)));
            else passes++;
            checks++;
            if (tick_o !== exp_tick(c)) $display("FAIL count_tick c=%0d got=%b exp=%b", c, tick_o, exp_tick(c));
            else passes++;
            advance();
        end
    endtask

    task automatic test_chase();
        int lit = 0;
        for (int i = 0; i < 300; i++) begin
            drive(i == 0, 2, 128);
            checks++;
            if (led_o !== N'(exp_led(c))) $display("FAIL chase_led c=%0d got=%b exp=%b", c, led_o, N'(exp_led(c)));
            else passes++;
            checks++;
            if (tick_o !== exp_tick(c)) $display("FAIL chase_tick c=%0d got=%b exp=%b", c, tick_o, exp_tick(c));
            else passes++;
            if (i >= 2 && i < 258 && led_o != '0) lit++;
            advance();
        end
        checks++;
        if (lit !== 128) $display("FAIL chase_duty lit_cycles=%0d exp=128", lit);
        else passes++;
    endtask

    task automatic test_breathe();
        for (int i = 0; i < 330; i++) begin
            drive(i == 0, 3, 255);
            checks++;
            if (led_o !== N'(exp_led(c))) $display("FAIL breathe_led c=%0d got=%b exp=%b", c, led_o, N'(exp_led(c)));
            else passes++;
            checks++;
            if (tick_o !== exp_tick(c)) $display("FAIL breathe_tick c=%0d got=%b exp=%b", c, tick_o, exp_tick(c));
            else passes++;
            advance();
        end
    endtask

    task automatic test_coincide();
        int base;
        int guard = 0;
        base = (L_h[c] < 0) ? 0 : L_h[c] + 1;
        while (((c - base) % TD) != TD - 1 && guard < 2 * TD) begin
            drive(1'b0, 0, 200);
            advance();
            guard++;
        end
        drive(1'b1, 1, 200);
        checks++;
        if (tick_o !== 1'b0) $display("FAIL coincide_tick c=%0d got=%b exp=0", c, tick_o);
        else passes++;
        advance();
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, 0, 200);
            checks++;
            if (tick_o !== ((i % TD) == 0)) $display("FAIL coincide_restart cyc_after_load=%0d got=%b exp=%b", i, tick_o, (i % TD) == 0);
            else passes++;
            checks++;
            if (led_o !== N'(exp_led(c))) $display("FAIL coincide_led c=%0d got=%b exp=%b", c, led_o, N'(exp_led(c)));
            else passes++;
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(15) == 0, $urandom_range(3), $urandom_range(255));
            checks++;
            if (led_o !== N'(exp_led(c))) $display("FAIL random_led c=%0d got=%b exp=%b", c, led_o, N'(exp_led(c)));
            else passes++;
            checks++;
            if (tick_o !== exp_tick(c)) $display("FAIL random_tick c=%0d got=%b exp=%b", c, tick_o, exp_tick(c));
            else passes++;
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 30; i++) begin
            drive(i == 0, 2, 255);
            advance();
        end
        @(posedge clkusr_100m);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led_o !== '0) $display("FAIL midreset_led got=%b exp=000000", led_o);
        else passes++;
        checks++;
        if (tick_o !== 1'b0) $display("FAIL midreset_tick got=%b exp=0", tick_o);
        else passes++;
        do_reset();
        for (int i = 0; i < 70; i++) begin
            drive(i == 40, 2, 255);
            checks++;
            if (led_o !== N'(exp_led(c))) $display("FAIL postreset_led c=%0d got=%b exp=%b", c, led_o, N'(exp_led(c)));
            else passes++;
            checks++;
            if (tick_o !== exp_tick(c)) $display("FAIL postreset_tick c=%0d got=%b exp=%b", c, tick_o, exp_tick(c));
            else passes++;
            advance();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count();
        test_chase();
        test_breathe();
        test_coincide();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
